// File: rtl/bfp_dot_product_stream.sv
`default_nettype none
// ============================================================================
// Module      : bfp_dot_product_stream
// Description : Streaming block-floating-point dot product. Collects up to
//               BLOCK_LEN FP16 operand pairs, aligns each vector to a shared
//               exponent, runs a sequential signed MAC and renormalises the
//               sum to a single FP32 result behind a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module bfp_dot_product_stream #(
    parameter int BLOCK_LEN = 4,
    parameter int MANT_SIZE = 10,
    parameter int EXP_SIZE  = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [EXP_SIZE+MANT_SIZE:0]     in_a,
    input  logic [EXP_SIZE+MANT_SIZE:0]     in_b,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_result,
    output logic                            out_nan,
    output logic                            busy
);

    // Accumulator width is derived from the operand format, never overridden.
    localparam int ACC_W  = 2*(MANT_SIZE+1) + $clog2(BLOCK_LEN) + 1;
    localparam int c_W    = 1 + EXP_SIZE + MANT_SIZE;
    localparam int c_IDX  = $clog2(BLOCK_LEN);
    localparam int c_CW   = c_IDX + 1;
    localparam int c_MW   = MANT_SIZE + 2;
    localparam int c_BIAS = (1 << (EXP_SIZE-1)) - 1;

    localparam logic [2:0] S_COLLECT = 3'd0;
    localparam logic [2:0] S_ALIGN   = 3'd1;
    localparam logic [2:0] S_MAC     = 3'd2;
    localparam logic [2:0] S_NORM    = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    logic [2:0]                 r_state;
    logic [2:0]                 w_next;
    logic [c_CW-1:0]            r_count;
    logic [c_CW-1:0]            r_mac_cnt;
    logic [c_W-1:0]             r_a  [BLOCK_LEN];
    logic [c_W-1:0]             r_b  [BLOCK_LEN];
    logic signed [c_MW-1:0]     r_ma [BLOCK_LEN];
    logic signed [c_MW-1:0]     r_mb [BLOCK_LEN];
    logic signed [c_MW-1:0]     w_ma [BLOCK_LEN];
    logic signed [c_MW-1:0]     w_mb [BLOCK_LEN];
    logic [BLOCK_LEN-1:0]       w_fill;
    logic [EXP_SIZE-1:0]        w_ea, w_eb, r_ea, r_eb;
    logic                       r_nan_acc;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    w_prod;
    logic [ACC_W-1:0]           w_mag;
    logic [7:0]                 w_p;
    logic [7:0]                 w_exp;
    logic [22:0]                w_frac;
    logic [31:0]                w_result;
    logic [31:0]                r_result;
    logic                       r_nan;
    logic                       w_xfer;

    // Decode one operand and shift its mantissa down to the shared exponent.
    function automatic logic signed [c_MW-1:0] f_align(
        input logic [c_W-1:0]      op,
        input logic [EXP_SIZE-1:0] e_max,
        input logic                fill
    );
        logic [EXP_SIZE-1:0] e;
        logic [MANT_SIZE:0]  m;
        logic [c_MW-1:0]     ext;
        e   = op[c_W-2 -: EXP_SIZE];
        m   = (e == '0 || !fill) ? '0 : {1'b1, op[MANT_SIZE-1:0]};
        m   = m >> (e_max - e);
        ext = {1'b0, m};
        return op[c_W-1] ? -ext : ext;
    endfunction

    // Gate with rst_n so the input is never advertised while held in reset.
    assign in_ready   = rst_n && (r_state == S_COLLECT);
    assign w_xfer     = in_valid && in_ready;
    assign out_valid  = (r_state == S_OUT);
    assign out_result = r_result;
    assign out_nan    = r_nan;
    assign busy       = (r_state != S_COLLECT);
    assign w_prod     = ACC_W'(r_ma[r_mac_cnt[c_IDX-1:0]]) * ACC_W'(r_mb[r_mac_cnt[c_IDX-1:0]]);

    // Shared exponents over filled slots, then per-slot alignment.
    always_comb begin
        w_ea   = '0;
        w_eb   = '0;
        w_fill = '0;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            w_fill[i] = (c_CW'(i) < r_count);
            if (w_fill[i] && r_a[i][c_W-2 -: EXP_SIZE] > w_ea) w_ea = r_a[i][c_W-2 -: EXP_SIZE];
            if (w_fill[i] && r_b[i][c_W-2 -: EXP_SIZE] > w_eb) w_eb = r_b[i][c_W-2 -: EXP_SIZE];
        end
        for (int i = 0; i < BLOCK_LEN; i++) begin
            w_ma[i] = f_align(r_a[i], w_ea, w_fill[i]);
            w_mb[i] = f_align(r_b[i], w_eb, w_fill[i]);
        end
    end

    // Renormalise the accumulator into an FP32 word.
    always_comb begin
        w_mag = r_acc[ACC_W-1] ? -r_acc : r_acc;
        w_p   = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_mag[i]) w_p = 8'(i);
        end
        w_exp  = 8'(int'(w_p) + int'(r_ea) + int'(r_eb) - 2*c_BIAS - 2*MANT_SIZE + 127);
        w_frac = 23'({w_mag, 23'b0} >> w_p);
        if (r_nan_acc)       w_result = 32'h7FC0_0000;
        else if (r_acc == 0) w_result = 32'h0000_0000;
        else                 w_result = {r_acc[ACC_W-1], w_exp, w_frac};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_COLLECT;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_COLLECT: if (w_xfer && (in_last || r_count == c_CW'(BLOCK_LEN-1))) w_next = S_ALIGN;
            S_ALIGN:   w_next = S_MAC;
            S_MAC:     if (r_mac_cnt == c_CW'(BLOCK_LEN-1)) w_next = S_NORM;
            S_NORM:    w_next = S_OUT;
            S_OUT:     if (out_ready) w_next = S_COLLECT;
            default:   w_next = S_COLLECT;
        endcase
    end

    // Datapath: pair capture, alignment, MAC and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_mac_cnt <= '0;
            r_acc     <= '0;
            r_ea      <= '0;
            r_eb      <= '0;
            r_nan_acc <= 1'b0;
            r_result  <= '0;
            r_nan     <= 1'b0;
            for (int i = 0; i < BLOCK_LEN; i++) begin
                r_a[i]  <= '0;
                r_b[i]  <= '0;
                r_ma[i] <= '0;
                r_mb[i] <= '0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_a[r_count[c_IDX-1:0]] <= in_a;
                        r_b[r_count[c_IDX-1:0]] <= in_b;
                        r_count <= r_count + 1'b1;
                        if (&in_a[c_W-2 -: EXP_SIZE] || &in_b[c_W-2 -: EXP_SIZE]) r_nan_acc <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    for (int i = 0; i < BLOCK_LEN; i++) begin
                        if (!w_fill[i]) begin
                            r_a[i] <= '0;
                            r_b[i] <= '0;
                        end
                        r_ma[i] <= w_ma[i];
                        r_mb[i] <= w_mb[i];
                    end
                    r_ea      <= w_ea;
                    r_eb      <= w_eb;
                    r_mac_cnt <= '0;
                    r_acc     <= '0;
                end
                S_MAC: begin
                    r_acc     <= r_acc + w_prod;
                    r_mac_cnt <= r_mac_cnt + 1'b1;
                end
                S_NORM: begin
                    r_result <= w_result;
                    r_nan    <= r_nan_acc;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_count   <= '0;
                        r_acc     <= '0;
                        r_nan_acc <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bfp_dot_product_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfp_dot_product_stream
// Description : Directed bench for bfp_dot_product_stream with a result
//               scoreboard filled as each block is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bfp_dot_product_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_nan;
    logic        busy;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          close_cyc = 0;
    logic [32:0] exp_q [$];

    bfp_dot_product_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_nan    (out_nan),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        close_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic chk_lat);
        int          waited;
        logic [32:0] e;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 100);
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_result"}, out_result, e[31:0]);
        chk({tag, "_nan"}, 32'(out_nan), 32'(e[32]));
        if (chk_lat) chk({tag, "_latency"}, 32'(cyc - close_cyc), 32'd6);
        chk({tag, "_inready_lo"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_inready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst_inready", 32'(in_ready), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rel_inready", 32'(in_ready), 32'd1);

        // in_last without a transfer must not close anything.
        @(negedge clk); in_last = 1'b1;
        @(negedge clk); in_last = 1'b0;
        chk("idle_last_busy", 32'(busy), 32'd0);

        // Full block of ones: 4.0.
        exp_q.push_back({1'b0, 32'h4080_0000});
        for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00, 1'b0);
        get_result("ones", 1'b1);

        // Zero-padded full block: 5.0.
        exp_q.push_back({1'b0, 32'h40A0_0000});
        send_pair(16'h3C00, 16'h4200, 1'b0);
        send_pair(16'h4000, 16'h3C00, 1'b0);
        send_pair(16'h0000, 16'h0000, 1'b0);
        send_pair(16'h0000, 16'h0000, 1'b0);
        get_result("five", 1'b1);

        // Single-pair block closed by in_last: -3.0.
        exp_q.push_back({1'b0, 32'hC040_0000});
        send_pair(16'h4000, 16'hBE00, 1'b1);
        #1;
        chk("short_busy", 32'(busy), 32'd1);
        get_result("neg3", 1'b1);

        // Alignment shift of 10: 1025.0.
        exp_q.push_back({1'b0, 32'h4480_2000});
        send_pair(16'h6400, 16'h3C00, 1'b0);
        send_pair(16'h3C00, 16'h3C00, 1'b1);
        get_result("align", 1'b1);

        // Inf operand with output back-pressure.
        exp_q.push_back({1'b1, 32'h7FC0_0000});
        send_pair(16'h7C00, 16'h3C00, 1'b0);
        for (int i = 0; i < 3; i++) send_pair(16'h3C00, 16'h3C00, 1'b0);
        repeat (7) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_ovalid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, 32'h7FC0_0000);
            chk("hold_nan", 32'(out_nan), 32'd1);
            chk("hold_inready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        get_result("nan", 1'b0);

        // Asynchronous reset during MAC discards the block.
        exp_q.push_back({1'b0, 32'h4080_0000});
        for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("mac_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        chk("arst_ovalid", 32'(out_valid), 32'd0);
        chk("arst_result", out_result, 32'd0);
        chk("arst_nan", 32'(out_nan), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_inready", 32'(in_ready), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rerel_inready", 32'(in_ready), 32'd1);
        exp_q.push_back({1'b0, 32'h4080_0000});
        for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00, 1'b0);
        get_result("after_rst", 1'b1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
